// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter; scanout reads always win over queued host pixel writes.
// Host (x, y, pixel) writes are linearised and buffered in a small FIFO drained on free RAM cycles.
module fb_arbiter #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pix_out,
    output logic              pix_valid
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [9:0] H_LAST = 10'(H_PIXELS - 1);
    localparam logic [9:0] V_LAST = 10'(V_LINES - 1);

    logic [9:0]        r_x, r_y;
    logic              r_autoinc, r_ovf, r_range;
    logic [ADDR_W-1:0] r_q_addr [FIFO_DEPTH];
    logic [7:0]        r_q_data [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_fetch;

    logic              w_wr, w_rd, w_data_wr, w_in_range, w_full, w_empty;
    logic              w_push, w_pop, w_active, w_read_slot;
    logic [9:0]        w_col, w_x_next, w_y_next;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
    logic [7:0]        w_status;

    // Row stride of 640 reduces to two shifts; other strides fall back to a multiplier.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] row, input logic [9:0] col);
        logic [ADDR_W-1:0] w_row;
        w_row = ADDR_W'(row);
        return (H_PIXELS == 640) ? (w_row << 9) + (w_row << 7) + ADDR_W'(col)
                                 : w_row * ADDR_W'(H_PIXELS) + ADDR_W'(col);
    endfunction

    assign w_wr        = chipselect & write;
    assign w_rd        = chipselect & read;
    assign w_data_wr   = w_wr && address == 3'd4;
    assign w_in_range  = r_x <= H_LAST && r_y <= V_LAST;
    assign w_full      = r_count == CW'(FIFO_DEPTH);
    assign w_empty     = r_count == '0;
    assign w_push      = w_data_wr && w_in_range && !w_full;
    assign w_col       = hcount[10:1];
    assign w_active    = w_col <= H_LAST && vcount <= V_LAST;
    assign w_read_slot = !hcount[0] && w_active;
    assign w_pop       = !w_read_slot && !w_empty;
    assign w_wr_addr   = lin_addr(r_y, r_x);
    assign w_rd_addr   = lin_addr(vcount, w_col);
    assign w_status    = {1'b0, r_range, r_ovf, w_empty, w_full, 3'(r_count)};
    assign w_x_next    = (r_x == H_LAST) ? '0 : r_x + 10'd1;
    assign w_y_next    = (r_x != H_LAST) ? r_y : (r_y == V_LAST) ? '0 : r_y + 10'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_autoinc <= 1'b0;
            r_ovf     <= 1'b0;
            r_range   <= 1'b0;
            readdata  <= '0;
        end else begin
            readdata <= (w_rd && address == 3'd6) ? w_status : 8'd0;
            if (w_wr) begin
                case (address)
                    3'd0: r_x[9:8] <= writedata[1:0];
                    3'd1: r_x[7:0] <= writedata;
                    3'd2: r_y[9:8] <= writedata[1:0];
                    3'd3: r_y[7:0] <= writedata;
                    3'd4: begin
                        if (!w_in_range) begin
                            r_range <= 1'b1;
                        end else begin
                            if (w_full) r_ovf <= 1'b1;
                            if (r_autoinc) begin
                                r_x <= w_x_next;
                                r_y <= w_y_next;
                            end
                        end
                    end
                    3'd5: begin
                        r_autoinc <= writedata[0];
                        if (writedata[1]) begin
                            r_ovf   <= 1'b0;
                            r_range <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= w_wr_addr;
            r_q_data[r_wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // r_fetch tracks scanout reads until their data comes back from the RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            r_fetch   <= '0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end else begin
            r_fetch <= {r_fetch[0], w_read_slot};
            mem_we  <= w_pop;
            if (w_read_slot) begin
                mem_addr <= w_rd_addr;
            end else if (w_pop) begin
                mem_addr  <= r_q_addr[r_rd_ptr];
                mem_wdata <= r_q_data[r_rd_ptr];
            end
            pix_valid <= r_fetch[1];
            pix_out   <= r_fetch[1] ? mem_rdata : (w_active ? pix_out : 8'd0);
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized scoreboard bench for fb_arbiter against a coordinate-level model.
module tb_fb_arbiter;
    logic        clk = 1'b0, reset_n = 1'b1;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [2:0]  address = '0;
    logic [7:0]  writedata = '0, readdata;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = 10'd500;
    logic [18:0] mem_addr;
    logic        mem_we, pix_valid;
    logic [7:0]  mem_wdata, pix_out, mem_rdata = '0;

    always #10 clk = ~clk;

    fb_arbiter dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .hcount(hcount), .vcount(vcount), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_out(pix_out), .pix_valid(pix_valid)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    // RAM stand-in: preloaded pattern, one-cycle read latency
    always @(posedge clk) mem_rdata <= pat(int'(mem_addr));

    typedef struct { int due; bit we; int addr; int d; } mem_t;
    typedef struct { int due; int v; } val_t;
    typedef struct { int addr; int d; } ent_t;

    mem_t exp_mem[$];
    val_t exp_pix[$];
    val_t exp_rd[$];
    ent_t mfifo[$];
    int   cyc = 0, zero_due = -1, mx = 0, my = 0;
    bit   mauto = 0, movf = 0, mrange = 0;
    int   checks = 0, errors = 0;
    bit   fin = 0, fin_done = 0;

    always @(posedge clk) begin : model
        int col, pre, st, a;
        bit act;
        ent_t e;
        cyc++;
        if (!reset_n) begin
            mx = 0; my = 0; mauto = 0; movf = 0; mrange = 0; zero_due = -1;
            mfifo.delete(); exp_mem.delete(); exp_pix.delete(); exp_rd.delete();
        end else begin
            col = int'(hcount[10:1]);
            pre = mfifo.size();
            st  = int'({1'b0, mrange, movf, pre == 0, pre == 4, 3'(pre)});
            act = col < 640 && int'(vcount) < 480;
            if (chipselect && read) exp_rd.push_back('{cyc, (address == 3'd6) ? st : 0});
            if (!act) zero_due = cyc;
            if (act && !hcount[0]) begin
                a = int'(vcount) * 640 + col;
                exp_mem.push_back('{cyc, 1'b0, a, 0});
                exp_pix.push_back('{cyc + 2, int'(pat(a))});
            end else if (pre > 0) begin
                e = mfifo.pop_front();
                exp_mem.push_back('{cyc, 1'b1, e.addr, e.d});
            end
            if (chipselect && write) begin
                case (address)
                    3'd0: mx = mx % 256 + 256 * int'(writedata[1:0]);
                    3'd1: mx = mx - mx % 256 + int'(writedata);
                    3'd2: my = my % 256 + 256 * int'(writedata[1:0]);
                    3'd3: my = my - my % 256 + int'(writedata);
                    3'd4: begin
                        if (mx >= 640 || my >= 480) mrange = 1;
                        else begin
                            if (pre == 4) movf = 1;
                            else mfifo.push_back('{my * 640 + mx, int'(writedata)});
                            if (mauto) begin
                                mx++;
                                if (mx == 640) begin mx = 0; my = (my + 1) % 480; end
                            end
                        end
                    end
                    3'd5: begin
                        mauto = writedata[0];
                        if (writedata[1]) begin movf = 0; mrange = 0; end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        mem_t m;
        val_t v;
        if (!reset_n) begin
            chk("reset_outputs", int'(|{readdata, mem_addr, mem_we, mem_wdata, pix_out, pix_valid}), 0);
        end else begin
            while (exp_mem.size() > 0 && exp_mem[0].due < cyc) begin
                m = exp_mem.pop_front();
                chk("mem_access_missed", m.due, cyc);
            end
            if (exp_mem.size() > 0 && exp_mem[0].due == cyc) begin
                m = exp_mem.pop_front();
                chk(m.we ? "ram_write_we" : "scan_read_we", int'(mem_we), int'(m.we));
                chk("mem_addr", int'(mem_addr), m.addr);
                if (m.we) chk("mem_wdata", int'(mem_wdata), m.d);
            end else begin
                chk("idle_mem_we", int'(mem_we), 0);
            end
            while (exp_pix.size() > 0 && exp_pix[0].due < cyc) begin
                v = exp_pix.pop_front();
                chk("pix_missed", v.due, cyc);
            end
            if (exp_pix.size() > 0 && exp_pix[0].due == cyc) begin
                v = exp_pix.pop_front();
                chk("pix_valid", int'(pix_valid), 1);
                chk("pix_out", int'(pix_out), v.v);
            end else begin
                chk("pix_valid_idle", int'(pix_valid), 0);
            end
            while (exp_rd.size() > 0 && exp_rd[0].due < cyc) begin
                v = exp_rd.pop_front();
                chk("readdata_missed", v.due, cyc);
            end
            if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
                v = exp_rd.pop_front();
                chk("readdata", int'(readdata), v.v);
            end
            if (zero_due == cyc && !pix_valid) chk("pix_out_blank", int'(pix_out), 0);
        end
        if (fin && !fin_done) begin
            fin_done = 1;
            chk("queues_drained", exp_mem.size() + exp_pix.size() + exp_rd.size() + mfifo.size(), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
    endtask

    task automatic status_rd();
        chipselect = 1'b1; read = 1'b1; address = 3'd6;
        step();
    endtask

    task automatic set_xy(input int x, input int y);
        reg_wr(3'd0, 8'(x >> 8));
        reg_wr(3'd1, 8'(x));
        reg_wr(3'd2, 8'(y >> 8));
        reg_wr(3'd3, 8'(y));
    endtask

    task automatic blank();
        hcount = '0; vcount = 10'd500;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (6) begin
            chipselect = 1'($urandom); write = 1'($urandom); read = 1'($urandom);
            address = 3'($urandom); writedata = 8'($urandom);
            hcount = 11'($urandom); vcount = 10'($urandom);
            @(posedge clk);
            #1;
        end
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        blank();
        reset_n = 1'b1;
        step();
        status_rd();
        repeat (2) step();

        set_xy(5, 2);
        reg_wr(3'd4, 8'hAB);
        repeat (4) step();
        status_rd();

        reg_wr(3'd5, 8'h01);
        set_xy(int'($urandom_range(0, 600)), 300);
        hcount = 11'(2 * $urandom_range(0, 560));
        vcount = 10'd10;
        for (int i = 0; i < 40; i++) begin
            if (i >= 2 && i < 6) begin
                chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = 8'($urandom);
            end
            step();
            hcount += 11'd1;
        end
        blank();
        repeat (4) step();
        reg_wr(3'd5, 8'h00);

        hcount = 11'(2 * $urandom_range(0, 639));
        vcount = 10'd20;
        set_xy(int'($urandom_range(0, 639)), 350);
        repeat (5) reg_wr(3'd4, 8'($urandom));
        status_rd();
        blank();
        repeat (8) step();
        status_rd();
        reg_wr(3'd5, 8'h02);
        status_rd();

        hcount = 11'd100;
        vcount = 10'd30;
        set_xy(10, 10);
        reg_wr(3'd4, 8'h11);
        reg_wr(3'd4, 8'h22);
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        blank();
        repeat (6) step();
        status_rd();

        reg_wr(3'd5, 8'h01);
        set_xy(639, 479);
        reg_wr(3'd4, 8'($urandom));
        reg_wr(3'd4, 8'($urandom));
        repeat (4) step();

        reg_wr(3'd5, 8'h00);
        set_xy(640, 5);
        reg_wr(3'd4, 8'h77);
        repeat (3) step();
        status_rd();
        reg_wr(3'd5, 8'h02);
        status_rd();
        repeat (2) step();

        for (int i = 0; i < 400; i++) begin
            hcount = 11'($urandom);
            vcount = 10'($urandom_range(0, 600));
            case ($urandom_range(0, 5))
                0: reg_wr(3'($urandom_range(0, 3)), 8'($urandom));
                1, 2: reg_wr(3'd4, 8'($urandom));
                3: reg_wr(3'd5, 8'($urandom_range(0, 3)));
                4: begin
                    chipselect = 1'b1; read = 1'b1; address = 3'($urandom);
                    step();
                end
                default: step();
            endcase
        end

        blank();
        repeat (10) step();
        fin = 1'b1;
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
